data_mem_responder: RTL and testbench

- Data-memory responder for the RISC-V core's load/store port; it is the memory end of the core's data-access request.
- Accepts one request at a time over a valid/ready handshake and inserts programmable wait states.
- Performs byte, half or word access selected by funct3, with sign/zero extension and misalignment/range checking.
- Returns the result over a valid/ready response channel, so the core can stall on slow memory.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/load_store_align.sv | 60 ++++++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// responder FSM states and the data-path width.
package riscv_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } rsp_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables and replicated write data,
// load lane extraction with sign/zero extension, and access legality flags.
module load_store_align
  import riscv_pkg::*;
(
  input  logic              i_write,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wword,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misalign,
  output logic              o_illegal
);

  logic [DATA_W-1:0] w_lane;

  assign w_lane = i_rword >> {i_off, 3'b000};

  assign o_misalign = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    o_be      = 4'b0000;
    o_wword   = i_wdata;
    o_rdata   = '0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_off;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
      end
      F3_H: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_rdata = i_rword;
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        o_rdata   = {{(DATA_W-8){1'b0}}, w_lane[7:0]};
        o_illegal = i_write;
      end
      F3_HU: begin
        o_rdata   = {{(DATA_W-16){1'b0}}, w_lane[15:0]};
        o_illegal = i_write;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of the core's load/store port: one request at a time, programmable
// wait states, byte/half/word access and a valid/ready response channel.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int              IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0]     BYTES    = 32'(4 * DEPTH_WORDS);
  localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  rsp_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic [31:0]       w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_range_err;
  logic [DATA_W-1:0] w_rword;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wword;
  logic [DATA_W-1:0] w_load_data;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_err;
  logic              w_mem_we;

  // Modular subtraction lets addresses below the base wrap into the range check.
  assign w_off       = r_addr - ADDR_BASE;
  assign w_idx       = w_off[IDX_W+1:2];
  assign w_range_err = (w_off >= BYTES);
  assign w_rword     = r_mem[w_idx];
  assign w_err       = w_range_err | w_misalign | w_illegal;
  assign w_mem_we    = (r_state == ST_ACCESS) && r_write && !w_err;

  load_store_align u_align (
    .i_write    (r_write),
    .i_funct3   (r_funct3),
    .i_off      (w_off[1:0]),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_load_data),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // NOTE: storage has no reset; its contents survive reset and only a write
  // enabled in ACCESS changes them.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= '0;
      r_wdata   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_write   <= req_write;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              r_cnt   <= CNT_LOAD;
              r_state <= ST_WAIT;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_ACCESS;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= w_err;
          rsp_rdata <= (w_err || r_write) ? '0 : w_load_data;
          r_state   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with three instances covering
// WAIT_CYCLES of 1, 0 and 3.
module tb_data_mem_responder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a  [3];
  logic        vld_a  [3];
  logic        rdy_a  [3];
  logic        wr_a   [3];
  logic [2:0]  f3_a   [3];
  logic [31:0] addr_a [3];
  logic [31:0] wd_a   [3];
  logic        rvld_a [3];
  logic        rrdy_a [3];
  logic [31:0] rd_a   [3];
  logic        err_a  [3];

  int n_total = 0;
  int n_bad   = 0;
  int exp_lat [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(rst_a[0]), .req_valid(vld_a[0]), .req_ready(rdy_a[0]),
    .req_write(wr_a[0]), .req_funct3(f3_a[0]), .req_addr(addr_a[0]),
    .req_wdata(wd_a[0]), .rsp_valid(rvld_a[0]), .rsp_ready(rrdy_a[0]),
    .rsp_rdata(rd_a[0]), .rsp_err(err_a[0])
  );

  data_mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst_a[1]), .req_valid(vld_a[1]), .req_ready(rdy_a[1]),
    .req_write(wr_a[1]), .req_funct3(f3_a[1]), .req_addr(addr_a[1]),
    .req_wdata(wd_a[1]), .rsp_valid(rvld_a[1]), .rsp_ready(rrdy_a[1]),
    .rsp_rdata(rd_a[1]), .rsp_err(err_a[1])
  );

  data_mem_responder #(.WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset(rst_a[2]), .req_valid(vld_a[2]), .req_ready(rdy_a[2]),
    .req_write(wr_a[2]), .req_funct3(f3_a[2]), .req_addr(addr_a[2]),
    .req_wdata(wd_a[2]), .rsp_valid(rvld_a[2]), .rsp_ready(rrdy_a[2]),
    .rsp_rdata(rd_a[2]), .rsp_err(err_a[2])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance d, checking handshake, latency and result.
  task automatic txn(input string tag, input int d, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int k;
    int lat;
    k = 0;
    while (!rdy_a[d] && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_rdy"}, 32'(rdy_a[d]), 32'd1);
    vld_a[d]  = 1'b1;
    wr_a[d]   = wr;
    f3_a[d]   = f3;
    addr_a[d] = addr;
    wd_a[d]   = wd;
    tick();
    vld_a[d] = 1'b0;
    lat = 0;
    while (!rvld_a[d] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_vld"}, 32'(rvld_a[d]), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat[d]));
    check({tag, "_rd"}, rd_a[d], exp_rd);
    check({tag, "_err"}, 32'(err_a[d]), 32'(exp_err));
    rrdy_a[d] = 1'b1;
    tick();
    rrdy_a[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_a[i]  = 1'b1;
      vld_a[i]  = 1'b0;
      wr_a[i]   = 1'b0;
      f3_a[i]   = 3'b000;
      addr_a[i] = '0;
      wd_a[i]   = '0;
      rrdy_a[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    tick();

    check("rst_rdy",  32'(rdy_a[0]),  32'd1);
    check("rst_rvld", 32'(rvld_a[0]), 32'd0);
    check("rst_rd",   rd_a[0],        32'd0);
    check("rst_err",  32'(err_a[0]),  32'd0);

    // Word store/load and lane extraction, one wait state.
    txn("sw_10",  0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("lw_10",  0, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("lb_13",  0, 1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    txn("lbu_13", 0, 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    txn("lh_12",  0, 1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    txn("lhu_10", 0, 1'b0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    txn("sb_11",  0, 1'b1, F3_B,  32'h11, 32'hAABBCC55, 32'h0, 1'b0);
    txn("lw_sb",  0, 1'b0, F3_W,  32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

    // Error cases must return zero data and leave storage untouched.
    txn("lw_mis",   0, 1'b0, F3_W,   32'h12,   32'h0,        32'h0, 1'b1);
    txn("sh_mis",   0, 1'b1, F3_H,   32'h11,   32'hFFFFFFFF, 32'h0, 1'b1);
    txn("ld_f3_3",  0, 1'b0, 3'b011, 32'h10,   32'h0,        32'h0, 1'b1);
    txn("lw_range", 0, 1'b0, F3_W,   32'h1000, 32'h0,        32'h0, 1'b1);
    txn("sw_range", 0, 1'b1, F3_W,   32'h1010, 32'h11111111, 32'h0, 1'b1);
    txn("sbu_ill",  0, 1'b1, F3_BU,  32'h10,   32'h22222222, 32'h0, 1'b1);
    txn("sw_f3_7",  0, 1'b1, 3'b111, 32'h10,   32'h33333333, 32'h0, 1'b1);
    txn("lw_keep",  0, 1'b0, F3_W,   32'h10,   32'h0, 32'hDEAD55EF, 1'b0);

    // Zero wait states with response back-pressure.
    txn("w0_sw", 1, 1'b1, F3_W, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
    vld_a[1]  = 1'b1;
    wr_a[1]   = 1'b0;
    f3_a[1]   = F3_W;
    addr_a[1] = 32'h0;
    tick();
    vld_a[1] = 1'b0;
    tick();
    check("w0_bp_vld0", 32'(rvld_a[1]), 32'd1);
    vld_a[1]  = 1'b1;
    wr_a[1]   = 1'b1;
    wd_a[1]   = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("w0_bp_vld", 32'(rvld_a[1]), 32'd1);
      check("w0_bp_rd",  rd_a[1],        32'h0BADF00D);
      check("w0_bp_rdy", 32'(rdy_a[1]),  32'd0);
    end
    vld_a[1]  = 1'b0;
    rrdy_a[1] = 1'b1;
    tick();
    rrdy_a[1] = 1'b0;
    check("w0_drop_vld", 32'(rvld_a[1]), 32'd0);
    check("w0_idle_rdy", 32'(rdy_a[1]),  32'd1);
    txn("w0_lw_keep", 1, 1'b0, F3_W, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);

    // Reset during WAIT drops the pending store.
    txn("w3_sw", 2, 1'b1, F3_W, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    txn("w3_lw", 2, 1'b0, F3_W, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
    vld_a[2]  = 1'b1;
    wr_a[2]   = 1'b1;
    f3_a[2]   = F3_W;
    addr_a[2] = 32'h20;
    wd_a[2]   = 32'h12345678;
    tick();
    vld_a[2] = 1'b0;
    tick();
    check("w3_wait_rdy", 32'(rdy_a[2]), 32'd0);
    rst_a[2] = 1'b1;
    #1;
    check("w3_rst_rdy",  32'(rdy_a[2]),  32'd1);
    check("w3_rst_rvld", 32'(rvld_a[2]), 32'd0);
    check("w3_rst_rd",   rd_a[2],        32'd0);
    check("w3_rst_err",  32'(err_a[2]),  32'd0);
    @(negedge clk);
    rst_a[2] = 1'b0;
    repeat (5) tick();
    check("w3_no_rsp", 32'(rvld_a[2]), 32'd0);
    txn("w3_lw_keep", 2, 1'b0, F3_W, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
